// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer master's two write ports among N_REQ pixel-pair producers.
// Define FB_ARB_FIXED_PRIO_EN for strict lowest-index priority; the default build is round-robin.
module fb_write_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fb_resetting,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr1,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr2,
    input  logic [N_REQ*DATA_W-1:0]    req_data1,
    input  logic [N_REQ*DATA_W-1:0]    req_data2,
    input  logic [N_REQ-1:0]           req_en1,
    input  logic [N_REQ-1:0]           req_en2,
    input  logic [N_REQ-1:0]           req_done,
    output logic [ADDR_W-1:0]          addr_wr1,
    output logic [ADDR_W-1:0]          addr_wr2,
    output logic [DATA_W-1:0]          data_wr1,
    output logic [DATA_W-1:0]          data_wr2,
    output logic                       wr1_en,
    output logic                       wr2_en,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       frame_complete
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               fb_rst_q;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   search;
    logic [IDX_W-1:0]   winner;
    logic               any_win;
    logic               start_run;
    logic               xfer;

    logic [ADDR_W-1:0]  sel_addr1, sel_addr2;
    logic [DATA_W-1:0]  sel_data1, sel_data2;
    logic               sel_en1, sel_en2;

    // Leaving CLEAR needs a registered falling edge of the master's clear flag.
    assign start_run = (state_q == S_CLEAR) && fb_rst_q && !fb_resetting;
    assign eligible  = req_valid & ~done_q;

`ifdef FB_ARB_FIXED_PRIO_EN
    assign search = eligible;
`else
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [N_REQ-1:0] hi_mask;

    // Requesters at or above the pointer take precedence; fall back to the wrapped set.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hi_mask[i] = (IDX_W'(i) >= rr_q);
        end
        search = (|(eligible & hi_mask)) ? (eligible & hi_mask) : eligible;
    end

    always_comb begin
        rr_d = rr_q;
        if (start_run) begin
            rr_d = '0;
        end else if (xfer) begin
            rr_d = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        winner  = '0;
        any_win = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (search[i]) begin
                winner  = IDX_W'(i);
                any_win = 1'b1;
            end
        end
    end

    // NOTE: every variable driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        req_ready = '0;
        unique case (state_q)
            S_CLEAR: begin
                if (start_run) begin
                    state_d = S_RUN;
                    done_d  = '0;
                end
            end
            S_RUN: begin
                if (any_win && !fb_resetting) begin
                    req_ready[winner] = 1'b1;
                end
                done_d = done_q | req_done;
                if (&done_d) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
        if (fb_resetting) begin
            state_d = S_CLEAR;
        end
    end

    assign xfer = |req_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_CLEAR;
            fb_rst_q <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            fb_rst_q <= fb_resetting;
            done_q   <= done_d;
        end
    end

    assign sel_addr1 = req_addr1[int'(winner)*ADDR_W +: ADDR_W];
    assign sel_addr2 = req_addr2[int'(winner)*ADDR_W +: ADDR_W];
    assign sel_data1 = req_data1[int'(winner)*DATA_W +: DATA_W];
    assign sel_data2 = req_data2[int'(winner)*DATA_W +: DATA_W];
    assign sel_en1   = req_en1[winner];
    assign sel_en2   = req_en2[winner];

    // Enables pulse once per accepted beat; address/data hold between beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_wr1 <= '0;
            addr_wr2 <= '0;
            data_wr1 <= '0;
            data_wr2 <= '0;
            wr1_en   <= 1'b0;
            wr2_en   <= 1'b0;
            grant_id <= '0;
        end else begin
            wr1_en <= 1'b0;
            wr2_en <= 1'b0;
            if (xfer) begin
                addr_wr1 <= sel_addr1;
                addr_wr2 <= sel_addr2;
                data_wr1 <= sel_data1;
                data_wr2 <= sel_data2;
                wr1_en   <= sel_en1;
                // Both pixels on one address: port 1 wins, port 2 is suppressed.
                wr2_en   <= sel_en2 & ~(sel_en1 & (sel_addr1 == sel_addr2));
                grant_id <= winner;
            end
        end
    end

    assign frame_complete = (state_q == S_DONE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration, frame and write-port rules.
module tb_fb_write_arbiter;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 4;
    localparam int GID_W  = $clog2(N_REQ);
    localparam int OUT_W  = 2 + 2*ADDR_W + 2*DATA_W + GID_W + 1;

    typedef enum int {P_CLEAR, P_RUN, P_DONE} phase_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    fb_resetting = 1'b0;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_addr1 = '0;
    logic [N_REQ*ADDR_W-1:0] req_addr2 = '0;
    logic [N_REQ*DATA_W-1:0] req_data1 = '0;
    logic [N_REQ*DATA_W-1:0] req_data2 = '0;
    logic [N_REQ-1:0]        req_en1 = '0;
    logic [N_REQ-1:0]        req_en2 = '0;
    logic [N_REQ-1:0]        req_done = '0;
    logic [ADDR_W-1:0]       addr_wr1, addr_wr2;
    logic [DATA_W-1:0]       data_wr1, data_wr2;
    logic                    wr1_en, wr2_en, frame_complete;
    logic [GID_W-1:0]        grant_id;
    logic [OUT_W-1:0]        act_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    phase_t            m_phase;
    bit                m_prev;
    int                m_ptr;
    bit [N_REQ-1:0]    m_done;
    int                m_win;
    bit                m_en1, m_en2;
    logic [ADDR_W-1:0] m_a1, m_a2;
    logic [DATA_W-1:0] m_d1, m_d2;
    int                m_gid;
    logic [N_REQ-1:0]  exp_ready;
    logic [OUT_W-1:0]  exp_out;

    fb_write_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .fb_resetting   (fb_resetting),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr1      (req_addr1),
        .req_addr2      (req_addr2),
        .req_data1      (req_data1),
        .req_data2      (req_data2),
        .req_en1        (req_en1),
        .req_en2        (req_en2),
        .req_done       (req_done),
        .addr_wr1       (addr_wr1),
        .addr_wr2       (addr_wr2),
        .data_wr1       (data_wr1),
        .data_wr2       (data_wr2),
        .wr1_en         (wr1_en),
        .wr2_en         (wr2_en),
        .grant_id       (grant_id),
        .frame_complete (frame_complete)
    );

    always #5 clock = ~clock;

    assign act_out = {wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2, grant_id, frame_complete};

    task automatic model_pack();
        exp_out = {m_en1, m_en2, m_a1, m_a2, m_d1, m_d2, GID_W'(m_gid), (m_phase == P_DONE)};
    endtask

    task automatic model_reset();
        m_phase = P_CLEAR;
        m_prev  = 1'b0;
        m_ptr   = 0;
        m_done  = '0;
        m_en1   = 1'b0;
        m_en2   = 1'b0;
        m_a1    = '0;
        m_a2    = '0;
        m_d1    = '0;
        m_d2    = '0;
        m_gid   = 0;
        m_win   = -1;
        exp_ready = '0;
        model_pack();
    endtask

    // Winner is the first eligible requester scanning upward from the pointer, modulo N_REQ.
    task automatic model_comb();
        int start;
`ifdef FB_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        m_win = -1;
        if (m_phase == P_RUN && !fb_resetting) begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (start + k) % N_REQ;
                if (m_win < 0 && req_valid[i] && !m_done[i]) m_win = i;
            end
        end
        exp_ready = '0;
        if (m_win >= 0) exp_ready = N_REQ'(1) << m_win;
    endtask

    task automatic model_update();
        model_comb();
        if (m_win >= 0) begin
            m_a1  = req_addr1[m_win*ADDR_W +: ADDR_W];
            m_a2  = req_addr2[m_win*ADDR_W +: ADDR_W];
            m_d1  = req_data1[m_win*DATA_W +: DATA_W];
            m_d2  = req_data2[m_win*DATA_W +: DATA_W];
            m_en1 = req_en1[m_win];
            m_en2 = req_en2[m_win] && !(req_en1[m_win] && (m_a1 == m_a2));
            m_gid = m_win;
            m_ptr = (m_win + 1) % N_REQ;
        end else begin
            m_en1 = 1'b0;
            m_en2 = 1'b0;
        end
        if (fb_resetting) begin
            m_phase = P_CLEAR;
        end else if (m_phase == P_CLEAR && m_prev) begin
            m_phase = P_RUN;
            m_done  = '0;
            m_ptr   = 0;
        end else if (m_phase == P_RUN) begin
            m_done = m_done | req_done;
            if (m_done == '1) m_phase = P_DONE;
        end
        m_prev = fb_resetting;
        model_pack();
    endtask

    // Inputs are driven 1 time unit after a rising edge; combinational outputs are sampled 1 later.
    task automatic settle();
        model_comb();
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic set_beat(input int i, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                            input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                            input logic e1, input logic e2);
        req_addr1[i*ADDR_W +: ADDR_W] = a1;
        req_addr2[i*ADDR_W +: ADDR_W] = a2;
        req_data1[i*DATA_W +: DATA_W] = d1;
        req_data2[i*DATA_W +: DATA_W] = d2;
        req_en1[i] = e1;
        req_en2[i] = e2;
    endtask

    task automatic rand_beats();
        logic [ADDR_W-1:0] a1, a2;
        for (int i = 0; i < N_REQ; i++) begin
            a1 = ADDR_W'($urandom());
            a2 = ($urandom_range(3) == 0) ? a1 : ADDR_W'($urandom());
            set_beat(i, a1, a2, DATA_W'($urandom()), DATA_W'($urandom()), 1'($urandom()), 1'($urandom()));
        end
    endtask

    // Clear pulse 1 -> 0; the block is in RUN with pointer 0 and no done flags afterwards.
    task automatic start_frame();
        req_done     = '0;
        fb_resetting = 1'b1;
        settle();
        tick();
        fb_resetting = 1'b0;
        settle();
        tick();
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = '1;
        rand_beats();
        model_reset();
        #1;
        checks++;
        if (act_out !== '0 || req_ready !== '0) begin
            failures++;
            $display("FAIL reset_values: out=%h ready=%b required out=0 ready=0", act_out, req_ready);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL clear_ready c=%0d: got %b required 000", c, req_ready);
            end
            tick();
            checks++;
            if (act_out !== '0 || act_out !== exp_out) begin
                failures++;
                $display("FAIL clear_out c=%0d: got %h required %h", c, act_out, exp_out);
            end
        end
        fb_resetting = 1'b1;
        settle();
        tick();
        fb_resetting = 1'b0;
        set_beat(0, 19'h100, 19'h0, 4'h5, 4'h0, 1'b1, 1'b0);
        settle();
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL falling_edge_ready: got %b required 000", req_ready);
        end
        tick();
        settle();
        checks++;
        if (req_ready !== 3'b001 || req_ready !== exp_ready) begin
            failures++;
            $display("FAIL first_grant_ready: got %b required 001", req_ready);
        end
        tick();
        checks++;
        if (wr1_en !== 1'b1 || addr_wr1 !== 19'h100 || data_wr1 !== 4'h5 || wr2_en !== 1'b0 ||
            grant_id !== '0 || act_out !== exp_out) begin
            failures++;
            $display("FAIL first_beat: got en1=%b addr1=%h data1=%h en2=%b gid=%0d required en1=1 addr1=100 data1=5 en2=0 gid=0",
                     wr1_en, addr_wr1, data_wr1, wr2_en, grant_id);
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int exp_g;
        start_frame();
        req_valid = '1;
        for (int c = 0; c < 9; c++) begin
`ifdef FB_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = c % N_REQ;
`endif
            rand_beats();
            settle();
            checks++;
            if (req_ready !== (N_REQ'(1) << exp_g) || req_ready !== exp_ready) begin
                failures++;
                $display("FAIL rr_ready c=%0d: got %b required %b", c, req_ready, N_REQ'(1) << exp_g);
            end
            tick();
            checks++;
            if (grant_id !== GID_W'(exp_g) || act_out !== exp_out) begin
                failures++;
                $display("FAIL rr_beat c=%0d: got gid=%0d out=%h required gid=%0d out=%h",
                         c, grant_id, act_out, exp_g, exp_out);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_hazard();
        req_valid = 3'b010;
        set_beat(1, 19'h2A0, 19'h2A0, 4'd3, 4'd7, 1'b1, 1'b1);
        settle();
        checks++;
        if (req_ready !== 3'b010) begin
            failures++;
            $display("FAIL hazard_ready: got %b required 010", req_ready);
        end
        tick();
        checks++;
        if (wr1_en !== 1'b1 || data_wr1 !== 4'd3 || addr_wr1 !== 19'h2A0 || wr2_en !== 1'b0 || act_out !== exp_out) begin
            failures++;
            $display("FAIL hazard_same_addr: got en1=%b d1=%0d en2=%b required en1=1 d1=3 en2=0",
                     wr1_en, data_wr1, wr2_en);
        end
        set_beat(1, 19'h2A0, 19'h2A4, 4'd3, 4'd7, 1'b1, 1'b1);
        settle();
        tick();
        checks++;
        if (wr1_en !== 1'b1 || wr2_en !== 1'b1 || data_wr2 !== 4'd7 || act_out !== exp_out) begin
            failures++;
            $display("FAIL hazard_diff_addr: got en1=%b en2=%b d2=%0d required en1=1 en2=1 d2=7",
                     wr1_en, wr2_en, data_wr2);
        end
        set_beat(1, 19'h2A0, 19'h2A0, 4'd3, 4'd7, 1'b0, 1'b1);
        settle();
        tick();
        checks++;
        if (wr1_en !== 1'b0 || wr2_en !== 1'b1 || act_out !== exp_out) begin
            failures++;
            $display("FAIL hazard_en2_only: got en1=%b en2=%b required en1=0 en2=1", wr1_en, wr2_en);
        end
        req_valid = '0;
        settle();
        tick();
        checks++;
        if (wr1_en !== 1'b0 || wr2_en !== 1'b0 || addr_wr2 !== 19'h2A0 || data_wr2 !== 4'd7 || act_out !== exp_out) begin
            failures++;
            $display("FAIL idle_hold: got en1=%b en2=%b addr2=%h d2=%0d required en=0 addr2=2a0 d2=7",
                     wr1_en, wr2_en, addr_wr2, data_wr2);
        end
    endtask

    task automatic test_done();
        start_frame();
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            req_done = (c == 0) ? 3'b001 : (c == 4) ? 3'b010 : (c == 8) ? 3'b100 : 3'b000;
            rand_beats();
            settle();
            checks++;
            if (req_ready !== exp_ready || (c > 0 && req_ready[0]) || (c > 4 && req_ready[1]) ||
                (c > 8 && req_ready !== '0)) begin
                failures++;
                $display("FAIL done_ready c=%0d: got %b required %b", c, req_ready, exp_ready);
            end
            tick();
            checks++;
            if (frame_complete !== (c >= 8) || act_out !== exp_out) begin
                failures++;
                $display("FAIL done_out c=%0d: got fc=%b out=%h required fc=%b out=%h",
                         c, frame_complete, act_out, c >= 8, exp_out);
            end
        end
        req_done     = '0;
        fb_resetting = 1'b1;
        settle();
        checks++;
        if (req_ready !== '0 || frame_complete !== 1'b1) begin
            failures++;
            $display("FAIL done_clear_same_cycle: got ready=%b fc=%b required ready=000 fc=1", req_ready, frame_complete);
        end
        tick();
        checks++;
        if (frame_complete !== 1'b0 || act_out !== exp_out) begin
            failures++;
            $display("FAIL done_clear_fc: got fc=%b required 0", frame_complete);
        end
        fb_resetting = 1'b0;
        req_valid    = '0;
        settle();
        tick();
    endtask

    task automatic test_fb_midrun();
        start_frame();
        req_valid = '1;
        for (int c = 0; c < 2; c++) begin
            rand_beats();
            settle();
            tick();
        end
        fb_resetting = 1'b1;
        settle();
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL midrun_gate: got %b required 000", req_ready);
        end
        tick();
        checks++;
        if (frame_complete !== 1'b0 || wr1_en !== 1'b0 || wr2_en !== 1'b0 || act_out !== exp_out) begin
            failures++;
            $display("FAIL midrun_out: got %h required %h", act_out, exp_out);
        end
        fb_resetting = 1'b0;
        settle();
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL midrun_clear_ready: got %b required 000", req_ready);
        end
        tick();
        settle();
        checks++;
        if (req_ready !== 3'b001) begin
            failures++;
            $display("FAIL midrun_resume: got %b required 001", req_ready);
        end
        tick();
        checks++;
        if (grant_id !== '0 || act_out !== exp_out) begin
            failures++;
            $display("FAIL midrun_resume_beat: got gid=%0d out=%h required gid=0 out=%h", grant_id, act_out, exp_out);
        end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        start_frame();
        req_valid = '1;
        rand_beats();
        set_beat(0, 19'h555, 19'h1AA, 4'hA, 4'h6, 1'b1, 1'b1);
        settle();
        tick();
        checks++;
        if (wr1_en !== 1'b1 || act_out !== exp_out) begin
            failures++;
            $display("FAIL areset_setup: got %h required %h", act_out, exp_out);
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act_out !== '0 || req_ready !== '0) begin
            failures++;
            $display("FAIL areset_immediate: got out=%h ready=%b required 0", act_out, req_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (act_out !== '0 || req_ready !== '0) begin
            failures++;
            $display("FAIL areset_held: got out=%h ready=%b required 0", act_out, req_ready);
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL areset_clear_ready c=%0d: got %b required 000", c, req_ready);
            end
            tick();
        end
        start_frame();
        settle();
        checks++;
        if (req_ready !== 3'b001) begin
            failures++;
            $display("FAIL areset_restart: got %b required 001", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            fb_resetting = ($urandom_range(15) == 0);
            req_valid    = N_REQ'($urandom());
            for (int i = 0; i < N_REQ; i++) req_done[i] = ($urandom_range(15) == 0);
            rand_beats();
            settle();
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL rand_ready c=%0d: got %b required %b", c, req_ready, exp_ready);
            end
            tick();
            checks++;
            if (act_out !== exp_out) begin
                failures++;
                $display("FAIL rand_out c=%0d: got %h required %h", c, act_out, exp_out);
            end
        end
        fb_resetting = 1'b0;
        req_valid    = '0;
        req_done     = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hazard();
        test_done();
        test_fb_midrun();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
